// File: rtl/staticio_pkg.sv
// staticio_pkg: shared definitions for the static-I/O transmit scheduler.
//   - state_e          : scheduler FSM state encoding
//   - NREQ_MAX         : largest legal number of external requesters
//   - HB_WORD_DEFAULT  : default heartbeat payload
//   - HALF_PERIOD / BIT_PERIOD / FRAME_CLKS : UART frame timing in core clocks
package staticio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } state_e;

  localparam int          NREQ_MAX        = 7;
  localparam logic [15:0] HB_WORD_DEFAULT = 16'hACF1;

  // UART frame: 17 bit times of 688 clk each (two half periods plus 2).
  localparam int HALF_PERIOD = 343;
  localparam int BIT_PERIOD  = 688;
  localparam int FRAME_BITS  = 17;
  localparam int FRAME_CLKS  = FRAME_BITS * BIT_PERIOD;

endpackage

// File: rtl/staticio_tx_sched_if.sv
// staticio_tx_sched_if: request bus and UART side-band of the transmit scheduler.
//   slave  modport : the scheduler (takes requests, drives the UART).
//   master modport : requesters/UART model facing the scheduler.
// Handshake: a requester raises req_valid[i] with req_data slot i and holds both
// until req_ready[i] pulses for one cycle; that pulse is the accept.
interface staticio_tx_sched_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               uart_load;
  logic [15:0]        uart_data;
  logic               uart_txint;
  logic               uart_tsre;
  logic               err_clr;
  logic               busy;
  logic [2:0]         grant_id;
  logic               timeout_err;

  modport slave (
    input  req_valid, req_data, uart_txint, uart_tsre, err_clr,
    output req_ready, uart_load, uart_data, busy, grant_id, timeout_err
  );

  modport master (
    output req_valid, req_data, uart_txint, uart_tsre, err_clr,
    input  req_ready, uart_load, uart_data, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/staticio_rr_pick.sv
// staticio_rr_pick: combinational round-robin picker.
//   i_pend  : pending mask, bit i = slot i (unused slots must be 0)
//   i_last  : slot of the previous grant
//   o_any   : some slot is pending
//   o_grant : first pending slot scanning upward from i_last+1, wrapping
// Scanning all 8 positions mod 8 is equivalent to wrapping at the real slot
// count because bits above the last real slot are always zero.
module staticio_rr_pick
  import staticio_pkg::*;
(
  input  logic [7:0] i_pend,
  input  logic [2:0] i_last,
  output logic       o_any,
  output logic [2:0] o_grant
);

  logic [2:0] w_idx;

  always_comb begin
    o_any   = 1'b0;
    o_grant = 3'd0;
    w_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      w_idx = i_last + 3'(k);
      if (!o_any && i_pend[w_idx]) begin
        o_any   = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/staticio_tx_sched.sv
// staticio_tx_sched: shares one static-I/O UART transmitter among NREQ word
// producers (plus an optional heartbeat slot), round-robin, one frame at a time.
// Ports:
//   clk, reset_n   : core clock, asynchronous active-low reset
//   bus (slave)    : requests, UART load/data, UART txint/tsre, status
//   o_dbg_state    : current FSM state
// Optional feature macro: STATICIO_TX_SCHED_HEARTBEAT_EN adds a heartbeat
// requester on slot NREQ that raises a request every HB_PERIOD clocks.
module staticio_tx_sched
  import staticio_pkg::*;
#(
  parameter int          NREQ           = 3,
  parameter logic [15:0] GAP_CYCLES     = 16'd0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd16384,
  parameter logic [25:0] HB_PERIOD      = 26'd19_000_000,
  parameter logic [15:0] HB_WORD        = HB_WORD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  staticio_tx_sched_if.slave   bus,
  output state_e               o_dbg_state
);

`ifdef STATICIO_TX_SCHED_HEARTBEAT_EN
  localparam int NSLOT = NREQ + 1;
`else
  localparam int NSLOT = NREQ;
`endif
  // Resetting to the highest slot makes slot 0 win the first arbitration.
  localparam logic [2:0] LAST_RST = 3'(NSLOT - 1);

  state_e            r_state;
  logic [15:0]       r_cnt;        // watchdog in WAIT_*, gap counter in GAP
  logic [2:0]        r_last;
  logic              r_uart_load;
  logic [15:0]       r_uart_data;
  logic [NREQ-1:0]   r_req_ready;
  logic              r_busy;
  logic [2:0]        r_grant_id;
  logic              r_timeout_err;

  logic [7:0]        w_pend;
  logic              w_any;
  logic [2:0]        w_grant;
  logic [15:0]       w_word;
  logic              w_wd_expired;

`ifdef STATICIO_TX_SCHED_HEARTBEAT_EN
  logic [25:0] r_hb_cnt;
  logic        r_hb_pending;
  logic        w_hb_tick;

  assign w_hb_tick = (r_hb_cnt == HB_PERIOD - 26'd1);

  // A tick beats the LOAD clear, so a tick landing on the heartbeat LOAD
  // leaves a fresh request pending; ticks while pending simply coalesce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hb_cnt     <= '0;
      r_hb_pending <= 1'b0;
    end else begin
      r_hb_cnt <= w_hb_tick ? 26'd0 : r_hb_cnt + 26'd1;
      if (w_hb_tick)
        r_hb_pending <= 1'b1;
      else if (r_state == ST_LOAD && r_grant_id == 3'(NREQ))
        r_hb_pending <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_pend = '0;
    w_pend[NREQ-1:0] = bus.req_valid;
`ifdef STATICIO_TX_SCHED_HEARTBEAT_EN
    w_pend[NREQ] = r_hb_pending;
`endif
  end

  // Any grant beyond the external slots can only be the heartbeat slot.
  always_comb begin
    w_word = HB_WORD;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == 3'(i)) w_word = bus.req_data[16*i +: 16];
    end
  end

  staticio_rr_pick u_pick (
    .i_pend  (w_pend),
    .i_last  (r_last),
    .o_any   (w_any),
    .o_grant (w_grant)
  );

  assign w_wd_expired = (r_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_last        <= LAST_RST;
      r_uart_load   <= 1'b0;
      r_uart_data   <= '0;
      r_req_ready   <= '0;
      r_busy        <= 1'b0;
      r_grant_id    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_uart_load <= 1'b0;
      r_req_ready <= '0;
      if (bus.err_clr) r_timeout_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_LOAD;
            r_uart_load <= 1'b1;
            r_req_ready <= (w_grant < 3'(NREQ)) ? (NREQ'(1) << w_grant) : '0;
            r_uart_data <= w_word;
            r_grant_id  <= w_grant;
            r_busy      <= 1'b1;
          end
        end
        // The grant is committed here, so a frame that later times out is
        // already counted as consumed and arbitration moves past it.
        ST_LOAD: begin
          r_last  <= r_grant_id;
          r_cnt   <= '0;
          r_state <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (bus.uart_txint) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_DONE;
          end else if (w_wd_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.uart_tsre) begin
            r_cnt <= '0;
            if (GAP_CYCLES != 16'd0) begin
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_wd_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_CYCLES - 16'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.uart_load   = r_uart_load;
  assign bus.uart_data   = r_uart_data;
  assign bus.req_ready   = r_req_ready;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;
  assign o_dbg_state     = r_state;

endmodule
